alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 32-bit datapath ALU.
- Executes single-cycle logic, arithmetic, compare and shift ops with a registered result.
- Executes iterative multi-cycle unsigned multiply/divide.
- Sits between the decode/operand-fetch stage and writeback; valid/ready on both sides so the pipeline can stall during long ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 8).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block accepts request this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sel  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- carry  output  1  ADD carry-out / SUB no-borrow (a >= b unsigned)
- overflow  output  1  signed overflow on ADD/SUB
- illegal  output  1  sel not a recognised code
- busy  output  1  multi-cycle op in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, result=0, zero=0, carry=0, overflow=0, illegal=0, busy=0, counter=0. Any in-flight op is aborted; nothing is emitted after reset release.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR: semantics unchanged from the previous ALU.
  - 0011 XOR.
  - 0111 SLT: signed compare, result 1 or 0.
  - 1000 SLTU: unsigned compare.
  - 0100 SLL, 0101 SRL, 1101 SRA: shift amount b[$clog2(WIDTH)-1:0].
  - 1001 MULU: low WIDTH bits of a*b.
  - 1010 DIVU, 1011 REMU.
  - 1110, 1111: illegal.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output slot holds result/flags stable while out_valid && !out_ready.
  - out_valid clears on a handshake unless a new result lands in the same cycle.
- Latency:
  - Single-cycle ops and illegal codes: out_valid the cycle after acceptance.
  - MULU/DIVU/REMU: exactly WIDTH+1 cycles after acceptance.
  - Back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
- FSM:
  - IDLE -> BUSY on accepting MULU/DIVU/REMU.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; counter runs 0..WIDTH-1.
  - BUSY -> DONE when counter==WIDTH-1.
  - DONE: write output slot, set out_valid, -> IDLE.
  - busy=1 in BUSY and DONE.
  - Inputs a/b/sel are latched at acceptance and ignored afterwards.
- Flags:
  - zero is valid for every op.
  - carry and overflow apply to ADD/SUB only and are 0 for all other ops.
  - SUB carry = (a >= b unsigned).
  - overflow: ADD = sign(a)==sign(b) && sign(res)!=sign(a); SUB = sign(a)!=sign(b) && sign(res)!=sign(a).
- Illegal sel: result 0, zero=1, illegal=1, 1-cycle latency, no state change otherwise.
- Divide by zero:
  - DIVU -> all ones, REMU -> a.
  - Still takes WIDTH+1 cycles (no early exit).
- Arithmetic wraps modulo 2^WIDTH; MULU high half is discarded.
- Simultaneous events:
  - out_ready while DONE writes the slot: the old result drains and the new result is loaded the same cycle.
  - in_valid while BUSY: in_ready=0, request not consumed.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: MULU/DIVU/REMU behave as above; BUSY/DONE states and counter are instantiated.
- Undefined:
  - 1001/1010/1011 are treated as illegal (result 0, illegal=1, 1-cycle latency).
  - busy is tied 0.
  - No BUSY/DONE logic is synthesised.

Test Plan:
- Reset mid-op (WIDTH=32): accept MULU a=7 b=9, assert rst_n=0 at cycle 10 -> all outputs 0 immediately; after release, no out_valid until a new request.
- ADD overflow: ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, carry=0, zero=0. ADD 0xFFFFFFFF+1 -> result 0, carry=1, zero=1.
- Compares: SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- Multi-cycle timing:
  - MULU 0x0000FFFF*0x00010001 -> 0xFFFFFFFF, out_valid exactly 33 cycles after acceptance.
  - in_ready=0 throughout busy=1.
- Division:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Backpressure:
  - Stream AND, OR, XOR with out_ready=0 -> first result held stable, in_ready=0 after first accept.
  - Release out_ready -> results in order, 1/cycle.
  - sel=1111 -> result 0, illegal=1.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : handshaked sequential ALU
//
// Single-cycle logic/arith/compare/shift ops land in a registered output slot
// one cycle after acceptance. With ALU_SEQ_MULDIV_EN defined, unsigned
// MULU/DIVU/REMU run iteratively (one shift-add or restoring-subtract step per
// cycle) and their result lands WIDTH+1 cycles after acceptance. Without the
// macro those three codes are reported as illegal and no iterative logic exists.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake; a, b, sel sampled on acceptance
//   out_valid / out_ready result handshake; slot holds while stalled
//   result                operation result
//   zero                  result == 0
//   carry                 ADD carry-out / SUB no-borrow (a >= b unsigned)
//   overflow              signed overflow on ADD/SUB
//   illegal               sel was not a recognised code
//   busy                  iterative op in progress
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (sel)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];           // no borrow out <=> a >= b
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            // Iterative codes never reach the slot through this path; when the
            // iterative unit is absent they fall out here as illegal.
            default: alu_ill = 1'b1;
        endcase
    end

    // ---------------- iterative unit / FSM ----------------
    logic             idle;
    logic             is_muldiv;
    logic             last_step;
    logic [WIDTH-1:0] multi_res;
    logic             accept;

    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // x: multiplicand / divisor, y: multiplier / dividend->quotient,
    // acc: product / partial remainder
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [WIDTH-1:0] step_acc, step_y;
    logic [WIDTH:0]   rem_sh;

    assign is_muldiv = (sel == OP_MULU) || (sel == OP_DIVU) || (sel == OP_REMU);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_muldiv) state_d = S_BUSY;
            S_BUSY:  if (last_step)           state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. The final step's value is written into the slot on the
    // BUSY->DONE edge, so DONE is the cycle the result is already visible while
    // the unit is still reported busy.
    always_comb begin
        idle      = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        last_step = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // One iteration: MSB-first shift-add for MULU, restoring divide otherwise.
    always_comb begin
        rem_sh   = {acc_q, y_q[WIDTH-1]};
        step_acc = acc_q;
        step_y   = y_q;
        if (op_q == OP_MULU) begin
            step_acc = (acc_q << 1) + (y_q[WIDTH-1] ? x_q : '0);
            step_y   = y_q << 1;
        end else if (rem_sh >= {1'b0, x_q}) begin
            // divisor 0 always subtracts: quotient all ones, remainder = a
            step_acc = WIDTH'(rem_sh - {1'b0, x_q});
            step_y   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_sh[WIDTH-1:0];
            step_y   = {y_q[WIDTH-2:0], 1'b0};
        end
        multi_res = (op_q == OP_DIVU) ? step_y : step_acc;
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (accept && is_muldiv) begin
            op_d  = sel;
            acc_d = '0;
            cnt_d = '0;
            x_d   = (sel == OP_MULU) ? a : b;
            y_d   = (sel == OP_MULU) ? b : a;
        end else if (state_q == S_BUSY) begin
            acc_d = step_acc;
            y_d   = step_y;
            cnt_d = last_step ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end
`else
    assign is_muldiv = 1'b0;
    assign idle      = 1'b1;
    assign busy      = 1'b0;
    assign last_step = 1'b0;
    assign multi_res = '0;
`endif

    // ---------------- output slot ----------------
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             ill_q, ill_d, out_valid_q, out_valid_d;

    assign in_ready = idle && (!out_valid_q || out_ready);

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept && !is_muldiv) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
        end else if (last_step) begin
            result_d    = multi_res;
            zero_d      = (multi_res == '0);
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            ill_d       = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = '0;
    logic         in_ready, out_valid, zero, carry, overflow, illegal, busy;
    logic [W-1:0] result;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic z, c, v, i;
        int   lat;
        int   acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_acc = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
        exp_t e;
        longint unsigned ux, uy;
        longint sx, sy, s;
        int sh;
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.i = 1'b0; e.lat = 1; e.acc = 0;
        ux = x; uy = y;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        case (op)
            4'h0: e.r = x & y;
            4'h1: e.r = x | y;
            4'h3: e.r = x ^ y;
            4'hC: e.r = ~(x | y);
            4'h2: begin
                e.r = W'(ux + uy);
                e.c = (ux + uy) >= 64'h1_0000_0000;
                s   = sx + sy;
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h6: begin
                e.r = W'(ux - uy);
                e.c = ux >= uy;
                s   = sx - sy;
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h7: e.r = (sx < sy) ? 1 : 0;
            4'h8: e.r = (ux < uy) ? 1 : 0;
            4'h4: e.r = x << sh;
            4'h5: e.r = x >> sh;
            4'hD: e.r = W'($signed(x) >>> sh);
`ifdef ALU_SEQ_MULDIV_EN
            4'h9: begin e.r = W'(ux * uy); e.lat = W + 1; end
            4'hA: begin e.r = (uy == 0) ? '1 : W'(ux / uy); e.lat = W + 1; end
            4'hB: begin e.r = (uy == 0) ? x : W'(ux % uy); e.lat = W + 1; end
`endif
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // One clock: drive after the falling edge, check a little later.
    task automatic cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] op, input logic ordy);
        bit ov_exp, busy_exp, ir_exp;
        exp_t e;
        @(negedge clk);
        in_valid = v; a = x; b = y; sel = op; out_ready = ordy;
        #1;
        ov_exp = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
`ifdef ALU_SEQ_MULDIV_EN
        busy_exp = (m_acc >= 0) && (cyc > m_acc) && (cyc <= m_acc + W + 1);
`else
        busy_exp = 1'b0;
`endif
        ir_exp = !busy_exp && (!ov_exp || ordy);
        chk("out_valid", 64'(out_valid), 64'(ov_exp));
        chk("busy", 64'(busy), 64'(busy_exp));
        chk("in_ready", 64'(in_ready), 64'(ir_exp));
        if (out_valid && ov_exp)
            chk("res{r,z,c,v,i}", 64'({result, zero, carry, overflow, illegal}),
                64'({q[0].r, q[0].z, q[0].c, q[0].v, q[0].i}));
        if (ov_exp && ordy) void'(q.pop_front());
        if (v && ir_exp) begin
            e = model(x, y, op);
            e.acc = cyc;
            q.push_back(e);
            if (e.lat > 1) m_acc = cyc;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
        cycle(1'b1, x, y, op, 1'b1);
        repeat (W + 3) cycle(1'b0, $urandom, $urandom, 4'h0, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst result", 64'(result), 64'(0));
        chk("rst flags{z,c,v,i,busy}", 64'({zero, carry, overflow, illegal, busy}), 64'(0));
        chk("rst in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // directed ops
        run_op(32'h7FFF_FFFF, 32'h1, 4'h2);
        run_op(32'hFFFF_FFFF, 32'h1, 4'h2);
        run_op(32'h0, 32'h1, 4'h6);
        run_op(32'h8000_0000, 32'h1, 4'h6);
        run_op(32'h1234_5678, 32'h1234_5678, 4'h6);
        run_op(32'hFFFF_FFFF, 32'h1, 4'h7);
        run_op(32'hFFFF_FFFF, 32'h1, 4'h8);
        run_op(32'h8000_0000, 32'h4, 4'hD);
        run_op(32'h1, 32'h1F, 4'h4);
        run_op(32'h0000_FFFF, 32'h0001_0001, 4'h9);
        run_op(32'd100, 32'd7, 4'hA);
        run_op(32'd100, 32'd7, 4'hB);
        run_op(32'hDEAD_BEEF, 32'h0, 4'hA);
        run_op(32'd5, 32'h0, 4'hB);
        run_op(32'h1234, 32'h5678, 4'hF);
        run_op(32'h1234, 32'h5678, 4'hE);

        // requests offered while busy must wait; operands must stay latched
        cycle(1'b1, 32'h0000_FFFF, 32'h0001_0001, 4'h9, 1'b1);
        repeat (W + 3) cycle(1'b1, $urandom, $urandom, 4'h1, 1'b1);
        repeat (3) cycle(1'b0, 0, 0, 4'h0, 1'b1);

        // backpressure: AND held, OR offered but stalled, then drain in order
        cycle(1'b1, 32'hF0F0_1234, 32'hFF00_FF00, 4'h0, 1'b0);
        repeat (3) cycle(1'b1, 32'h0F0F_0000, 32'h0000_00FF, 4'h1, 1'b0);
        cycle(1'b1, 32'h0F0F_0000, 32'h0000_00FF, 4'h1, 1'b1);
        cycle(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 4'h3, 1'b1);
        cycle(1'b1, 32'h1, 32'h2, 4'hF, 1'b1);
        repeat (3) cycle(1'b0, 0, 0, 4'h0, 1'b1);

        // randomized traffic
        repeat (500)
            cycle(1'($urandom_range(0, 1)), rnd_val(), rnd_val(),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        repeat (W + 3) cycle(1'b0, 0, 0, 4'h0, 1'b1);

        // reset in the middle of a multiply
        cycle(1'b1, 32'd7, 32'd9, 4'h9, 1'b1);
        repeat (9) cycle(1'b0, 0, 0, 4'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'(0));
        chk("midrst result", 64'(result), 64'(0));
        chk("midrst flags{z,c,v,i,busy}", 64'({zero, carry, overflow, illegal, busy}), 64'(0));
        q.delete();
        m_acc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) cycle(1'b0, 0, 0, 4'h0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h1, 4'h2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
